// File: rtl/reg_file_scoreboard.sv
// Register file with hardwired zero, write-to-read bypass and pending-write scoreboard.
// Optional interrupt-entry PC save into ISR_REG is enabled by defining REGFILE_ISR_EN.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int ISR_REG    = 30
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [ADDR_WIDTH-1:0] in_address_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] out1_address_i,
    input  logic [ADDR_WIDTH-1:0] out2_address_i,
    output logic [DATA_WIDTH-1:0] out1_o,
    output logic [DATA_WIDTH-1:0] out2_o,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    output logic                  busy1_o,
    output logic                  busy2_o
`ifdef REGFILE_ISR_EN
    ,
    input  logic                  irq_i,
    input  logic [DATA_WIDTH-1:0] irq_pc_i,
    output logic                  write_ready_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ISR_ADDR = ADDR_WIDTH'(ISR_REG);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [DEPTH-1:0]      pending_d;
    logic                  writeReady;
    logic                  writeAccepted;
    logic                  irqSave;
    logic [DATA_WIDTH-1:0] irqPc;

`ifdef REGFILE_ISR_EN
    assign writeReady    = ~irq_i;
    assign irqSave       = irq_i & reset_n_i;
    assign irqPc         = irq_pc_i;
    assign write_ready_o = writeReady;
`else
    assign writeReady    = 1'b1;
    assign irqSave       = 1'b0;
    assign irqPc         = '0;
`endif

    assign writeAccepted = write_en_i & reset_n_i & writeReady
                         & ~(ZERO_EN & (in_address_i == '0));

    // Read priority: hardwired zero, then the ISR save, then the WB bypass, then storage.
    function automatic logic [DATA_WIDTH-1:0] readPort(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wrAcc,
        input logic [ADDR_WIDTH-1:0] wrAddr,
        input logic [DATA_WIDTH-1:0] wrData,
        input logic                  isrSave,
        input logic [DATA_WIDTH-1:0] isrData,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (ZERO_EN && addr == '0)
            return '0;
        else if (isrSave && addr == ISR_ADDR)
            return isrData;
        else if (wrAcc && addr == wrAddr)
            return wrData;
        else
            return stored;
    endfunction

    assign out1_o = readPort(out1_address_i, writeAccepted, in_address_i, in_i,
                             irqSave, irqPc, regs_q[out1_address_i]);
    assign out2_o = readPort(out2_address_i, writeAccepted, in_address_i, in_i,
                             irqSave, irqPc, regs_q[out2_address_i]);

    assign busy1_o = pending_q[out1_address_i]
                   & ~(writeAccepted & (out1_address_i == in_address_i))
                   & ~(irqSave & (out1_address_i == ISR_ADDR));
    assign busy2_o = pending_q[out2_address_i]
                   & ~(writeAccepted & (out2_address_i == in_address_i))
                   & ~(irqSave & (out2_address_i == ISR_ADDR));

    // Issue is applied last so a new producer supersedes a completing one.
    always_comb begin
        pending_d = pending_q;
        if (writeAccepted)
            pending_d[in_address_i] = 1'b0;
        if (irqSave)
            pending_d[ISR_ADDR] = 1'b0;
        if (issue_en_i && !(ZERO_EN && issue_addr_i == '0))
            pending_d[issue_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            if (writeAccepted)
                regs_q[in_address_i] <= in_i;
            if (irqSave)
                regs_q[ISR_ADDR] <= irqPc;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard with hand-computed expectations.
// The interrupt-save steps are compiled only when REGFILE_ISR_EN is defined.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] inData;
    logic [4:0]  inAddress;
    logic        writeEn;
    logic [4:0]  out1Address;
    logic [4:0]  out2Address;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        issueEn;
    logic [4:0]  issueAddr;
    logic        busy1;
    logic        busy2;
`ifdef REGFILE_ISR_EN
    logic        irq;
    logic [31:0] irqPc;
    logic        writeReady;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG(1),
        .ISR_REG(30)
    ) dut (
        .clk_i(clk),
        .reset_n_i(resetN),
        .in_i(inData),
        .in_address_i(inAddress),
        .write_en_i(writeEn),
        .out1_address_i(out1Address),
        .out2_address_i(out2Address),
        .out1_o(out1),
        .out2_o(out2),
        .issue_en_i(issueEn),
        .issue_addr_i(issueAddr),
        .busy1_o(busy1),
        .busy2_o(busy2)
`ifdef REGFILE_ISR_EN
        ,
        .irq_i(irq),
        .irq_pc_i(irqPc),
        .write_ready_o(writeReady)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] addr,
                                 input logic [31:0] data);
        writeEn   = we;
        inAddress = addr;
        inData    = data;
    endtask

    // Advance past the next rising edge; sampling happens 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN      = 1'b0;
        issueEn     = 1'b0;
        issueAddr   = '0;
        out1Address = '0;
        out2Address = '0;
        applyStimulus(1'b0, 5'd0, 32'h0);
`ifdef REGFILE_ISR_EN
        irq   = 1'b0;
        irqPc = '0;
`endif
        tick();
        tick();
        resetN = 1'b1;
        out1Address = 5'd5;
        out2Address = 5'd12;
        #1;
        checkOutput("reset_out1", out1, 32'h0);
        checkOutput("reset_out2", out2, 32'h0);
        checkOutput("reset_busy1", {31'b0, busy1}, 32'h0);
        checkOutput("reset_busy2", {31'b0, busy2}, 32'h0);

        // Write r5 and read it on both ports, then reset clears it.
        applyStimulus(1'b1, 5'd5, 32'h0000_00AA);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        out1Address = 5'd5;
        out2Address = 5'd5;
        #1;
        checkOutput("r5_out1", out1, 32'h0000_00AA);
        checkOutput("r5_out2", out2, 32'h0000_00AA);
        resetN = 1'b0;
        tick();
        checkOutput("r5_after_reset", out1, 32'h0);
        resetN = 1'b1;

        // Same-cycle bypass and value retained after the edge.
        out1Address = 5'd7;
        applyStimulus(1'b1, 5'd7, 32'h1234_5678);
        #1;
        checkOutput("bypass_r7", out1, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("stored_r7", out1, 32'h1234_5678);

        // Hardwired zero register: no write, no bypass, never pending.
        out1Address = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        checkOutput("r0_no_bypass", out1, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("r0_no_write", out1, 32'h0);
        issueEn   = 1'b1;
        issueAddr = 5'd0;
        tick();
        issueEn = 1'b0;
        #1;
        checkOutput("r0_never_busy", {31'b0, busy1}, 32'h0);

        // Scoreboard: issue sets, write releases same cycle, issue+write keeps pending.
        issueEn   = 1'b1;
        issueAddr = 5'd3;
        tick();
        issueEn     = 1'b0;
        out1Address = 5'd3;
        out2Address = 5'd3;
        #1;
        checkOutput("r3_busy1", {31'b0, busy1}, 32'h1);
        checkOutput("r3_busy2", {31'b0, busy2}, 32'h1);
        applyStimulus(1'b1, 5'd3, 32'h0000_0033);
        #1;
        checkOutput("r3_release_busy", {31'b0, busy1}, 32'h0);
        checkOutput("r3_release_data", out1, 32'h0000_0033);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("r3_cleared", {31'b0, busy1}, 32'h0);
        issueEn   = 1'b1;
        issueAddr = 5'd3;
        applyStimulus(1'b1, 5'd3, 32'h0000_0044);
        tick();
        issueEn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("r3_set_wins", {31'b0, busy1}, 32'h1);
        checkOutput("r3_value_44", out1, 32'h0000_0044);

        // Issue and write to different addresses both take effect.
        issueEn   = 1'b1;
        issueAddr = 5'd10;
        applyStimulus(1'b1, 5'd3, 32'h0000_0045);
        tick();
        issueEn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0);
        out2Address = 5'd10;
        #1;
        checkOutput("r3_after_diff", {31'b0, busy1}, 32'h0);
        checkOutput("r10_after_diff", {31'b0, busy2}, 32'h1);

        // Reset beats a simultaneous write and clears pending.
        issueEn   = 1'b1;
        issueAddr = 5'd9;
        tick();
        issueEn     = 1'b0;
        out1Address = 5'd9;
        #1;
        checkOutput("r9_busy", {31'b0, busy1}, 32'h1);
        resetN = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h0000_0055);
        #1;
        checkOutput("r9_no_bypass_in_reset", out1, 32'h0);
        tick();
        resetN = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("r9_busy_after_reset", {31'b0, busy1}, 32'h0);
        checkOutput("r9_data_after_reset", out1, 32'h0);
        checkOutput("r10_busy_after_reset", {31'b0, busy2}, 32'h0);

`ifdef REGFILE_ISR_EN
        // Interrupt save refuses the coinciding writeback for one cycle.
        applyStimulus(1'b1, 5'd4, 32'h0000_0011);
        tick();
        out1Address = 5'd4;
        out2Address = 5'd30;
        irq   = 1'b1;
        irqPc = 32'h0000_0400;
        applyStimulus(1'b1, 5'd4, 32'h0000_0077);
        #1;
        checkOutput("irq_write_ready", {31'b0, writeReady}, 32'h0);
        checkOutput("irq_r4_refused", out1, 32'h0000_0011);
        checkOutput("irq_r30_bypass", out2, 32'h0000_0400);
        tick();
        irq = 1'b0;
        #1;
        checkOutput("irq_ready_again", {31'b0, writeReady}, 32'h1);
        checkOutput("irq_r30_stored", out2, 32'h0000_0400);
        checkOutput("irq_r4_held_unchanged", dut.regs_q[4], 32'h0000_0011);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("irq_r4_written", out1, 32'h0000_0077);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
